// File: rtl/instr_readback_sequencer.sv
// Read-back burst sequencer: walks instruction-register addresses, captures the returned
// words through a latency pipeline into a credit-guarded output FIFO with valid/ready drain.

package instr_readback_pkg;
  typedef logic [4:0] address_t;

  typedef struct packed {
    logic [3:0]  opc;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [15:0] rezultat;
  } instruction_t;
endpackage

module irs_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] occ_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      occ_q, occ_d;
  logic             do_push, do_pop;

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    do_pop  = pop_i && (occ_q != '0);
    do_push = push_i && ((occ_q != FULL) || do_pop);
    occ_d   = occ_q;
    if (do_push && !do_pop) begin
      occ_d = occ_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      occ_d = occ_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign empty_o    = (occ_q == '0);
  assign occ_o      = occ_q;
endmodule

module instr_readback_sequencer
  import instr_readback_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_ORDER   = 0,
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [4:0]   start_addr,
  input  logic [5:0]   count,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         out_valid,
  input  logic         out_ready,
  output instruction_t out_word,
  output logic [4:0]   out_addr,
  output logic         busy,
  output logic         done
);
  localparam int IW    = $bits(instruction_t);
  localparam int EW    = IW + 5;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t   state_q;
  address_t read_pointer_q, next_addr_q;
  logic [5:0] count_q, issued_q;
  logic       done_q;

  logic [READ_LATENCY-1:0] pipe_vld_q;
  address_t                pipe_addr_q [READ_LATENCY];

  logic [OCC_W-1:0] occ;
  logic [EW-1:0]    head_dat;
  logic             fifo_empty;
  logic [7:0]       inflight, used;
  logic             issue, pop, final_hs;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + {7'd0, pipe_vld_q[i]};
    end
  end

  // Credits = depth minus everything already buffered or still in flight.
  assign used     = 8'(occ) + inflight;
  assign issue    = (state_q == RUN) && (issued_q != count_q) && (used < 8'(FIFO_DEPTH));
  assign pop      = out_valid && out_ready;
  assign final_hs = (state_q == FLUSH) && pop && (occ == OCC_W'(1)) && (inflight == 8'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      read_pointer_q <= 5'h1F;
      next_addr_q    <= '0;
      count_q        <= '0;
      issued_q       <= '0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (count == 6'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= RUN;
              next_addr_q <= start_addr;
              count_q     <= count;
              issued_q    <= '0;
            end
          end
        end
        RUN: begin
          if (issue) begin
            read_pointer_q <= next_addr_q;
            next_addr_q    <= (READ_ORDER != 0) ? next_addr_q - 5'd1 : next_addr_q + 5'd1;
            issued_q       <= issued_q + 6'd1;
            if (issued_q + 6'd1 == count_q) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          if (final_hs) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_addr_q[i] <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_addr_q[0] <= next_addr_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
    end
  end

  irs_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (pipe_vld_q[READ_LATENCY-1]),
    .push_dat_i ({instruction_word, pipe_addr_q[READ_LATENCY-1]}),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .empty_o    (fifo_empty),
    .occ_o      (occ)
  );

  assign read_pointer = read_pointer_q;
  assign out_valid    = !fifo_empty;
  assign out_word     = fifo_empty ? '0 : instruction_t'(head_dat[EW-1:5]);
  assign out_addr     = fifo_empty ? 5'd0 : head_dat[4:0];
  assign busy         = (state_q != IDLE);
  // The burst-end pulse must coincide with the final handshake, so it bypasses the register.
  assign done         = done_q | (final_hs & reset_n);
endmodule

// File: tb/tb_instr_readback_sequencer.sv
// Scoreboard bench: two sequencer instances (incrementing/latency 1, decrementing/latency 2)
// driven with random bursts and checked against an address/register model.

module tb_instr_readback_sequencer;
  import instr_readback_pkg::*;

  typedef struct {
    logic [4:0]   a;
    instruction_t w;
    bit           last;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn [2], start_s [2], rdy [2], ov [2], busy [2], done [2];
  logic [4:0]   sa_s [2], oa [2];
  logic [5:0]   cnt_s [2];
  address_t     rp [2];
  instruction_t ow [2];
  instruction_t iw0, iw1;
  instruction_t regs [32];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  sb_t q0 [$];
  sb_t q1 [$];

  int           iss [2]      = '{0, 0};
  int           acc [2]      = '{0, 0};
  int           done_cnt [2] = '{0, 0};
  int           zero_due [2] = '{-1, -1};
  logic [4:0]   prev_rp [2]  = '{5'h1F, 5'h1F};
  logic [4:0]   st_a [2];
  instruction_t st_w [2];
  bit           stall [2]    = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: instance 0 sees it combinationally, instance 1 through one register stage.
  assign iw0 = regs[rp[0]];
  always @(posedge clk) iw1 <= regs[rp[1]];

  instr_readback_sequencer #(.FIFO_DEPTH(4), .READ_ORDER(0), .READ_LATENCY(1)) dut_inc (
    .clk(clk), .reset_n(rstn[0]), .start(start_s[0]), .start_addr(sa_s[0]), .count(cnt_s[0]),
    .read_pointer(rp[0]), .instruction_word(iw0), .out_valid(ov[0]), .out_ready(rdy[0]),
    .out_word(ow[0]), .out_addr(oa[0]), .busy(busy[0]), .done(done[0]));

  instr_readback_sequencer #(.FIFO_DEPTH(2), .READ_ORDER(1), .READ_LATENCY(2)) dut_dec (
    .clk(clk), .reset_n(rstn[1]), .start(start_s[1]), .start_addr(sa_s[1]), .count(cnt_s[1]),
    .read_pointer(rp[1]), .instruction_word(iw1), .out_valid(ov[1]), .out_ready(rdy[1]),
    .out_word(ow[1]), .out_addr(oa[1]), .busy(busy[1]), .done(done[1]));

  function automatic int depth_of(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic void chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0h expected %0h at cycle %0d", name, 0, act, exp, cyc);
    end
  endfunction

  function automatic void sb_push(input int k, input sb_t e);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic int sb_size(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic sb_t sb_pop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic void sb_clear(input int k);
    if (k == 0) q0.delete(); else q1.delete();
  endfunction

  task automatic mon_step(input int k);
    sb_t e;
    bit  exp_done;
    if (!rstn[k]) begin
      prev_rp[k] = 5'h1F;
      iss[k]     = 0;
      acc[k]     = 0;
      stall[k]   = 1'b0;
      return;
    end
    exp_done = (cyc == zero_due[k]);
    if (stall[k]) begin
      chk(ov[k] && (ow[k] == st_w[k]) && (oa[k] == st_a[k]), "stall_stable", 64'(oa[k]), 64'(st_a[k]));
    end
    if (ov[k] && rdy[k]) begin
      chk(sb_size(k) != 0, "unexpected_output", 64'(oa[k]), 64'(0));
      if (sb_size(k) != 0) begin
        e = sb_pop(k);
        chk(oa[k] == e.a, "out_addr", 64'(oa[k]), 64'(e.a));
        chk(ow[k] == e.w, "out_word", 64'(ow[k]), 64'(e.w));
        if (e.last) exp_done = 1'b1;
      end
      acc[k]++;
    end
    chk(done[k] == exp_done, "done", 64'(done[k]), 64'(exp_done));
    if (done[k]) done_cnt[k]++;
    if (rp[k] != prev_rp[k]) begin
      iss[k]++;
      prev_rp[k] = rp[k];
      chk((iss[k] - acc[k]) <= depth_of(k), "outstanding", 64'(iss[k] - acc[k]), 64'(depth_of(k)));
    end
    stall[k] = ov[k] && !rdy[k];
    st_w[k]  = ow[k];
    st_a[k]  = oa[k];
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic check_reset_vals(input int k);
    chk(ov[k] == 1'b0, "rst_out_valid", 64'(ov[k]), 64'(0));
    chk(busy[k] == 1'b0, "rst_busy", 64'(busy[k]), 64'(0));
    chk(rp[k] == 5'h1F, "rst_read_pointer", 64'(rp[k]), 64'(5'h1F));
    chk(oa[k] == 5'd0, "rst_out_addr", 64'(oa[k]), 64'(0));
    chk(ow[k] == '0, "rst_out_word", 64'(ow[k]), 64'(0));
    chk(done[k] == 1'b0, "rst_done", 64'(done[k]), 64'(0));
  endtask

  task automatic apply_reset(input int k, input int n);
    rdy[k]     = 1'b0;
    start_s[k] = 1'b0;
    rstn[k]    = 1'b0;
    sb_clear(k);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rstn[k] = 1'b1;
    @(negedge clk);
    check_reset_vals(k);
    @(posedge clk);
    #1;
  endtask

  // mode 0: out_ready held high; 1: random ready plus stray starts; 2: 10 stalled cycles then toggling.
  task automatic run_burst(input int k, input logic [4:0] sa, input int cnt, input int mode);
    sb_t        e;
    logic [4:0] a;
    int         it, first_v, done_c, d0, i0;
    bit         fin, busy_seen;
    it = 0;
    while (busy[k] && it < 200) begin
      @(posedge clk);
      #1;
      it++;
    end
    chk(!busy[k], "idle_before_start", 64'(busy[k]), 64'(0));
    for (int i = 0; i < cnt; i++) begin
      a      = (k == 1) ? sa - 5'(i) : sa + 5'(i);
      e.a    = a;
      e.w    = regs[a];
      e.last = (i == cnt - 1);
      sb_push(k, e);
    end
    d0 = done_cnt[k];
    i0 = iss[k];
    start_s[k] = 1'b1;
    sa_s[k]    = sa;
    cnt_s[k]   = 6'(cnt);
    @(posedge clk);
    #1;
    start_s[k] = 1'b0;
    if (cnt == 0) zero_due[k] = cyc;
    first_v   = -1;
    done_c    = -1;
    fin       = 1'b0;
    busy_seen = 1'b0;
    for (it = 0; it < 3000 && !fin; it++) begin
      case (mode)
        0:       rdy[k] = 1'b1;
        1:       rdy[k] = 1'($urandom_range(0, 1));
        default: rdy[k] = (it < 10) ? 1'b0 : it[0];
      endcase
      if (mode == 1 && busy[k] && $urandom_range(0, 7) == 0) begin
        start_s[k] = 1'b1;
        sa_s[k]    = 5'($urandom);
        cnt_s[k]   = 6'($urandom_range(1, 32));
      end
      @(negedge clk);
      if (busy[k]) busy_seen = 1'b1;
      if (ov[k] && first_v < 0) first_v = cyc;
      if (done[k]) begin
        done_c = cyc;
        fin    = 1'b1;
      end
      @(posedge clk);
      #1;
      start_s[k] = 1'b0;
    end
    chk(fin, "done_timeout", 64'(fin), 64'(1));
    rdy[k] = 1'b0;
    @(negedge clk);
    chk(!busy[k], "busy_after_done", 64'(busy[k]), 64'(0));
    chk(done_cnt[k] - d0 == 1, "done_count", 64'(done_cnt[k] - d0), 64'(1));
    chk(sb_size(k) == 0, "all_delivered", 64'(sb_size(k)), 64'(0));
    if (cnt == 0) begin
      chk(iss[k] == i0, "zero_no_read", 64'(iss[k] - i0), 64'(0));
      chk(!busy_seen, "zero_no_busy", 64'(busy_seen), 64'(0));
    end
    if (k == 0 && mode == 0 && cnt > 0 && fin) begin
      chk(done_c - first_v == cnt - 1, "zero_bubble", 64'(done_c - first_v), 64'(cnt - 1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic mid_reset_test();
    sb_t e;
    int  a0, d0, it;
    for (int i = 0; i < 8; i++) begin
      e.a    = 5'(9 + i);
      e.w    = regs[e.a];
      e.last = (i == 7);
      sb_push(0, e);
    end
    a0 = acc[0];
    rdy[0]     = 1'b1;
    start_s[0] = 1'b1;
    sa_s[0]    = 5'd9;
    cnt_s[0]   = 6'd8;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    for (it = 0; it < 100 && (acc[0] - a0) < 3; it++) begin
      @(posedge clk);
      #1;
    end
    chk(acc[0] - a0 == 3, "accepted_before_reset", 64'(acc[0] - a0), 64'(3));
    d0 = done_cnt[0];
    apply_reset(0, 1);
    repeat (5) @(negedge clk);
    chk(done_cnt[0] == d0, "no_done_after_reset", 64'(done_cnt[0] - d0), 64'(0));
    chk(!busy[0], "busy_after_reset", 64'(busy[0]), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] r;
    for (int i = 0; i < 32; i++) begin
      r       = {$urandom, $urandom};
      regs[i] = r[35:0];
    end
    for (int k = 0; k < 2; k++) begin
      rstn[k]    = 1'b0;
      start_s[k] = 1'b0;
      rdy[k]     = 1'b0;
      sa_s[k]    = '0;
      cnt_s[k]   = '0;
    end
    apply_reset(0, 3);
    apply_reset(1, 1);

    run_burst(0, 5'd0, 20, 0);
    run_burst(0, 5'd30, 4, 0);
    run_burst(0, 5'd5, 0, 0);
    run_burst(0, 5'd7, 32, 2);
    mid_reset_test();
    run_burst(0, 5'd12, 8, 1);
    for (int n = 0; n < 6; n++) begin
      run_burst(0, 5'($urandom_range(0, 31)), $urandom_range(0, 32), $urandom_range(0, 2));
    end

    run_burst(1, 5'd2, 5, 0);
    run_burst(1, 5'd0, 32, 2);
    run_burst(1, 5'd20, 0, 1);
    for (int n = 0; n < 4; n++) begin
      run_burst(1, 5'($urandom_range(0, 31)), $urandom_range(1, 32), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/instr_readback_sequencer.md
INSTR_READBACK_SEQUENCER -- requirements
Module: instr_readback_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output buffer entries; power of two, 2..16.
REQ-002 Parameter READ_ORDER, default 0: 0 = incrementing addresses, 1 = decrementing addresses.
REQ-003 Parameter READ_LATENCY, default 1: clocks from a read_pointer change to a valid instruction_word.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a read-back burst.
REQ-007 start_addr  input  5  first register address of the burst.
REQ-008 count  input  6  entries to read, 0..32.
REQ-009 read_pointer  output  address_t (5)  address driven to the instruction register.
REQ-010 instruction_word  input  instruction_t  register contents for the addressed location.
REQ-011 out_valid  output  1  out_word/out_addr hold a valid entry.
REQ-012 out_ready  input  1  consumer accepts the entry when out_valid and out_ready are both high.
REQ-013 out_word  output  instruction_t  captured instruction word (opc, op_a, op_b, rezultat).
REQ-014 out_addr  output  5  address the entry was read from.
REQ-015 busy  output  1  burst in progress.
REQ-016 done  output  1  one-cycle pulse when the last entry of a burst has been accepted downstream.

Function
REQ-017 FSM states SHALL be IDLE, RUN, FLUSH.
REQ-018 IDLE->RUN on start with count != 0; latch start_addr and count; set busy=1 on the next cycle.
REQ-019 start with count == 0 in IDLE SHALL perform no reads, SHALL keep busy=0, and SHALL pulse done exactly one cycle later.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 In RUN, one address SHALL be issued per cycle while credits are available.
REQ-022 Credits = FIFO_DEPTH - occupancy - in-flight reads; no address SHALL be issued at 0 credits.
REQ-023 After each issue, read_pointer SHALL advance by +1 (READ_ORDER=0) or -1 (READ_ORDER=1), modulo 32 (31->0, 0->31).
REQ-024 instruction_word SHALL be captured exactly READ_LATENCY cycles after the issue, together with the issued address, into the FIFO tail.
REQ-025 RUN->FLUSH when the issued count equals the latched count.
REQ-026 FLUSH->IDLE when the FIFO is empty and no reads are in flight; done pulses on the cycle the final handshake occurs; busy=0 from the next cycle.
REQ-027 out_word and out_addr SHALL come from the FIFO head, and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 Output order SHALL equal issue order; no entry is dropped or duplicated.
REQ-029 A FIFO push and pop in the same cycle at full or empty SHALL both succeed, with occupancy unchanged.
REQ-030 The FIFO SHALL never overflow; the credit rule guarantees this.
REQ-031 Zero-bubble throughput: with out_ready held at 1, one entry per cycle once the pipeline is filled.
REQ-032 read_pointer SHALL hold its last value when not issuing.

Reset
REQ-033 On reset_n=0 at a clock edge: state=IDLE, read_pointer=5'h1F, FIFO emptied, in-flight reads discarded, out_valid=0, busy=0, done=0, out_word='0, out_addr=0.
REQ-034 Reset asserted mid-burst SHALL abort the burst with no done pulse; start is ignored while reset_n=0.

Verification
REQ-035 start_addr=0, count=20, READ_ORDER=0, out_ready=1 -> addresses 0..19 in order, 20 handshakes, done once, busy low afterwards.
REQ-036 start_addr=30, count=4, READ_ORDER=0 -> out_addr sequence 30,31,0,1.
REQ-037 start_addr=2, count=5, READ_ORDER=1 -> out_addr sequence 2,1,0,31,30.
REQ-038 count=32 with out_ready low for 10 cycles, then toggling -> at most FIFO_DEPTH reads outstanding, outputs stable while stalled, all 32 entries delivered once in order, and out_word matches the register model.
REQ-039 count=0 -> no read_pointer change, done pulse one cycle after start.
REQ-040 reset_n low for 1 cycle after 3 of 8 entries are accepted -> out_valid=0, busy=0, no done pulse; a new start then runs normally.
